// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default oversampling ratio
// and the parity helper used by both uart_tx_op and uart_rx_op.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_CHECK = 3'd3,
    ST_STOP  = 3'd4,
    ST_BREAK = 3'd5
  } uart_state_e;

  // Expected parity bit: even -> XOR of data, odd -> XNOR of data.
  function automatic logic parity_calc(input logic [7:0] data, input logic even);
    return even ? (^data) : (~^data);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchronizer, oversampling tick counter and bit-decision strobe for uart_rx_op.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 vote around the bit centre, decided one tick later.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sample_tick_i,
  input  logic uart_rx_i,
  input  logic hold_i,
  output logic rx_s_o,
  output logic bit_strobe_o,
  output logic bit_val_o
);

  localparam int CW  = $clog2(OVERSAMPLE);
  localparam int MID = OVERSAMPLE / 2 - 1;
`ifdef UART_RX_MAJORITY_EN
  localparam int STROBE_PT = MID + 1;
`else
  localparam int STROBE_PT = MID;
`endif
  localparam logic [CW-1:0] STROBE_C = CW'(STROBE_PT);
  localparam logic [CW-1:0] LAST_C   = CW'(OVERSAMPLE - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] tick_cnt_q;

  // Counter is held at zero while the FSM waits for an edge, so every bit
  // centre of the frame lands on the same counter phase.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q     <= 2'b11;
      tick_cnt_q <= '0;
    end else begin
      sync_q <= {sync_q[0], uart_rx_i};
      if (sample_tick_i) begin
        if (hold_i || tick_cnt_q == LAST_C) tick_cnt_q <= '0;
        else                                tick_cnt_q <= tick_cnt_q + 1'b1;
      end
    end
  end

  assign rx_s_o       = sync_q[1];
  assign bit_strobe_o = sample_tick_i && !hold_i && (tick_cnt_q == STROBE_C);

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] PRE_C = CW'(MID - 1);
  localparam logic [CW-1:0] MID_C = CW'(MID);
  logic [1:0] maj_q;

  always_ff @(posedge clk_i) begin
    if (sample_tick_i) begin
      if (tick_cnt_q == PRE_C) maj_q[0] <= rx_s_o;
      if (tick_cnt_q == MID_C) maj_q[1] <= rx_s_o;
    end
  end

  assign bit_val_o = (maj_q[0] & maj_q[1]) | (rx_s_o & (maj_q[0] | maj_q[1]));
`else
  assign bit_val_o = rx_s_o;
`endif

endmodule

// File: rtl/uart_rx_op.sv
// UART receiver: 8-bit LSB-first frames with optional parity, valid/error pulses.
// Optional macro UART_RX_MAJORITY_EN selects majority-vote bit sampling in uart_rx_sampler.
module uart_rx_op
  import uart_pkg::*;
#(
  parameter logic VERIFY_ON   = 1'b0,
  parameter logic VERIFY_EVEN = 1'b0,
  parameter int   OVERSAMPLE  = OVERSAMPLE_DEF
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       sample_tick_i,
  input  logic       uart_rx_i,
  output logic [7:0] dataout_o,
  output logic       data_valid_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       uart_busy_o
);

  uart_state_e state_q;
  logic [7:0]  dataout_q;
  logic [7:0]  shreg_q;
  logic [2:0]  bit_cnt_q;
  logic        par_bad_q;
  logic        valid_q, par_err_q, frame_err_q, busy_q;
  logic        rx_s, bit_strobe, bit_val, hold;

  assign hold = (state_q == ST_IDLE) || (state_q == ST_BREAK);

  uart_rx_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .sample_tick_i(sample_tick_i),
    .uart_rx_i    (uart_rx_i),
    .hold_i       (hold),
    .rx_s_o       (rx_s),
    .bit_strobe_o (bit_strobe),
    .bit_val_o    (bit_val)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      dataout_q   <= 8'h00;
      bit_cnt_q   <= 3'd0;
      par_bad_q   <= 1'b0;
      valid_q     <= 1'b0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      valid_q     <= 1'b0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      if (sample_tick_i) begin
        unique case (state_q)
          ST_IDLE: if (!rx_s) begin
            state_q <= ST_START;
            busy_q  <= 1'b1;
          end
          ST_START: if (bit_strobe) begin
            if (bit_val) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              bit_cnt_q <= 3'd0;
              par_bad_q <= 1'b0;
              state_q   <= ST_DATA;
            end
          end
          ST_DATA: if (bit_strobe) begin
            shreg_q[bit_cnt_q] <= bit_val;
            bit_cnt_q          <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= VERIFY_ON ? ST_CHECK : ST_STOP;
          end
          ST_CHECK: if (bit_strobe) begin
            par_bad_q <= (bit_val != parity_calc(shreg_q, VERIFY_EVEN));
            state_q   <= ST_STOP;
          end
          ST_STOP: if (bit_strobe) begin
            if (bit_val) begin
              dataout_q <= shreg_q;
              valid_q   <= 1'b1;
              par_err_q <= par_bad_q;
              busy_q    <= 1'b0;
              state_q   <= ST_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= ST_BREAK;
            end
          end
          ST_BREAK: if (rx_s) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign dataout_o    = dataout_q;
  assign data_valid_o = valid_q;
  assign parity_err_o = par_err_q;
  assign frame_err_o  = frame_err_q;
  assign uart_busy_o  = busy_q;

endmodule

// File: tb/tb_uart_rx_op.sv
// Scoreboard bench for uart_rx_op: one receiver without parity, one with even parity.
module tb_uart_rx_op;

  localparam int OS   = 16;
  localparam int TDIV = 2;
  localparam int BITC = OS * TDIV;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset   = 1'b1;
  logic tick    = 1'b0;
  logic rx_line = 1'b1;
  logic sel     = 1'b0;
  logic rx0, rx1;
  int   cyc = 0;

  always @(posedge clk) begin
    tick <= ~tick;
    cyc  <= cyc + 1;
  end

  assign rx0 = sel ? 1'b1 : rx_line;
  assign rx1 = sel ? rx_line : 1'b1;

  logic [7:0] d0, d1;
  logic v0, p0, f0, b0, v1, p1, f1, b1;

  uart_rx_op #(.VERIFY_ON(1'b0), .VERIFY_EVEN(1'b0), .OVERSAMPLE(OS)) dut0 (
    .clk_i(clk), .reset_i(reset), .sample_tick_i(tick), .uart_rx_i(rx0),
    .dataout_o(d0), .data_valid_o(v0), .parity_err_o(p0), .frame_err_o(f0), .uart_busy_o(b0));

  uart_rx_op #(.VERIFY_ON(1'b1), .VERIFY_EVEN(1'b1), .OVERSAMPLE(OS)) dut1 (
    .clk_i(clk), .reset_i(reset), .sample_tick_i(tick), .uart_rx_i(rx1),
    .dataout_o(d1), .data_valid_o(v1), .parity_err_o(p1), .frame_err_o(f1), .uart_busy_o(b1));

  typedef struct packed {
    logic       which;
    logic       is_frame;
    logic       perr;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int t_prev0 = 0;
  int t_last0 = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic which, input logic is_frame, input logic perr, input logic [7:0] data);
    exp_t e;
    e.which = which; e.is_frame = is_frame; e.perr = perr; e.data = data;
    sb.push_back(e);
  endtask

  task automatic handle_evt(input logic which, input logic v, input logic f, input logic p, input logic [7:0] d);
    exp_t e;
    if (sb.size() == 0) begin
      check_eq("unexpected_evt", {29'd0, v, f, p}, 32'd0);
    end else begin
      e = sb.pop_front();
      check_eq("evt_dut",   {31'd0, which}, {31'd0, e.which});
      check_eq("evt_valid", {31'd0, v}, {31'd0, ~e.is_frame});
      check_eq("evt_ferr",  {31'd0, f}, {31'd0, e.is_frame});
      check_eq("evt_perr",  {31'd0, p}, {31'd0, e.perr});
      check_eq("evt_data",  {24'd0, d}, {24'd0, e.data});
    end
    if (v && !which) begin
      t_prev0 = t_last0;
      t_last0 = cyc;
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (v0 | f0 | p0) handle_evt(1'b0, v0, f0, p0, d0);
      if (v1 | f1 | p1) handle_evt(1'b1, v1, f1, p1, d1);
    end
  end

  task automatic drive_bit(input logic v);
    rx_line = v;
    repeat (BITC) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    rx_line = 1'b1;
    repeat (n * BITC) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (pen) drive_bit(pbit);
    drive_bit(stop);
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_data0", {24'd0, d0}, 32'd0);
    check_eq("rst_busy0", {31'd0, b0}, 32'd0);
    check_eq("rst_valid0", {31'd0, v0}, 32'd0);
    check_eq("rst_ferr0", {31'd0, f0}, 32'd0);
    check_eq("rst_perr1", {31'd0, p1}, 32'd0);
    check_eq("rst_data1", {24'd0, d1}, 32'd0);
    idle_bits(2);

    push_exp(1'b0, 1'b0, 1'b0, 8'hA5);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    check_eq("a5_busy_low", {31'd0, b0}, 32'd0);
    check_eq("a5_data", {24'd0, d0}, 32'h0A5);
    idle_bits(2);

    sel = 1'b1;
    push_exp(1'b1, 1'b0, 1'b0, 8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    idle_bits(2);
    push_exp(1'b1, 1'b0, 1'b1, 8'h3C);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    check_eq("par_data", {24'd0, d1}, 32'h03C);
    idle_bits(2);
    sel = 1'b0;
    idle_bits(1);

    // Bad stop bit, long break, then a clean frame.
    push_exp(1'b0, 1'b1, 1'b0, 8'hA5);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    rx_line = 1'b0;
    repeat (20 * BITC) @(posedge clk);
    #1;
    check_eq("brk_busy", {31'd0, b0}, 32'd1);
    check_eq("brk_data_hold", {24'd0, d0}, 32'h0A5);
    idle_bits(2);
    check_eq("brk_exit_busy", {31'd0, b0}, 32'd0);
    push_exp(1'b0, 1'b0, 1'b0, 8'h81);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    idle_bits(2);
    check_eq("post_brk_data", {24'd0, d0}, 32'h081);

    // Four-tick low glitch.
    rx_line = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_eq("glitch_busy_hi", {31'd0, b0}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rx_line = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_eq("glitch_busy_lo", {31'd0, b0}, 32'd0);
    idle_bits(2);

    // Reset in the middle of bit 3 of 0xFF.
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    rx_line = 1'b1;
    repeat (BITC / 2) @(posedge clk);
    #1;
    check_eq("mid_busy", {31'd0, b0}, 32'd1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_mid_busy", {31'd0, b0}, 32'd0);
    check_eq("rst_mid_data", {24'd0, d0}, 32'd0);
    idle_bits(8);
    push_exp(1'b0, 1'b0, 1'b0, 8'h12);
    send_frame(8'h12, 1'b0, 1'b0, 1'b1);
    idle_bits(2);
    check_eq("after_rst_data", {24'd0, d0}, 32'h012);

    // Back-to-back frames with no idle gap.
    push_exp(1'b0, 1'b0, 1'b0, 8'h00);
    push_exp(1'b0, 1'b0, 1'b0, 8'hFF);
    send_frame(8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    idle_bits(2);
    check_eq("b2b_gap_clks", t_last0 - t_prev0, 10 * BITC);
    check_eq("b2b_data", {24'd0, d0}, 32'h0FF);

    check_eq("sb_drain", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_op.md
# uart_rx_op

Serial receiver for the UART link: samples an asynchronous `uart_rx_i` line with a 16× oversampling tick, reassembles 8-bit LSB-first frames (start, 8 data, optional parity, stop) and presents each byte with a one-cycle valid pulse plus error flags. It is the receive-side counterpart of `uart_tx_op` and uses the same frame format and parity parameters. It sits between the board pin and the byte-consuming logic, and everything runs in the system clock domain.

## Interface
Parameters:
- `VERIFY_ON`, 1'b0: a parity bit follows the data bits.
- `VERIFY_EVEN`, 1'b0: 1 = expected parity is `^data` (even); 0 = expected parity is `~^data` (odd).
- `OVERSAMPLE`, 16: sample ticks per bit. Must be ≥ 8 and even.

Ports:
- `clk_i` in 1: system clock. Single clock; reset is synchronous and active-high.
- `reset_i` in 1: synchronous active-high reset.
- `sample_tick_i` in 1: one-`clk_i` pulse at OVERSAMPLE × baud.
- `uart_rx_i` in 1: asynchronous serial line, idle high.
- `dataout_o` out 8: last received byte. Holds until the next valid frame.
- `data_valid_o` out 1: one-cycle pulse when a frame completes with a correct stop bit.
- `parity_err_o` out 1: pulses together with `data_valid_o` when the parity is wrong. Only active when `VERIFY_ON`=1.
- `frame_err_o` out 1: one-cycle pulse when the stop bit is sampled low.
- `uart_busy_o` out 1: high from start-bit detection until return to IDLE.

## Operation
- **Input synchronizer.** `uart_rx_i` passes through a 2-flop synchronizer. Both flops reset to 1. All decisions use the synchronized value `rx_s`.
- **Tick counter.** `tick_cnt` has width $clog2(OVERSAMPLE). Center point MID = OVERSAMPLE/2−1 (7 at default).
- **States:** IDLE, START, DATA, CHECK, STOP, BREAK. All state and counter updates happen only on cycles with `sample_tick_i`=1.
- **IDLE:**
  - If `rx_s`=0, go to START with `tick_cnt`=0 and `uart_busy_o`=1.
- **START:**
  - At `tick_cnt`=MID, re-check `rx_s`. If it is 1, treat the event as a glitch and return to IDLE with busy low. If it is 0, clear `tick_cnt`, set `bit_cnt`=0 and go to DATA.
- **DATA:**
  - At each `tick_cnt`=OVERSAMPLE−1 boundary, which lands on the next bit's center, shift the sampled bit into `shreg[bit_cnt]` (LSB first).
  - After bit 7, go to CHECK if `VERIFY_ON`, else to STOP.
- **CHECK:**
  - Sample the parity bit and compare it with the expected parity of `shreg`.
  - Latch the mismatch into `par_bad`, then go to STOP.
- **STOP:**
  - Sample at the bit center.
  - Stop bit = 1: `dataout_o`<=`shreg`, pulse `data_valid_o`, pulse `parity_err_o`=`par_bad`, go to IDLE.
  - Stop bit = 0: pulse `frame_err_o`, do not update `dataout_o`, go to BREAK.
- **BREAK:**
  - Wait until `rx_s`=1, then go to IDLE. A line held low never causes a false restart.
- **Reset values:** state IDLE, `dataout_o`=8'h00, all pulses 0, `uart_busy_o`=0, synchronizer=1.
- **Reset mid-frame:** aborts the frame with no pulses. Reception restarts only on a new falling edge seen from IDLE.
- **No downstream back-pressure.** The consumer must take `dataout_o` before the next stop-bit center, about 10 bit times later.

## Timing
- Input latency: 2 `clk_i` cycles of synchronizer delay before `rx_s` reflects the pin.
- The output pulses assert on the `clk_i` cycle after the tick that samples the stop-bit center and last exactly one cycle.
- `uart_busy_o` falls on the same edge that `data_valid_o` rises.
- Frame length seen at the pulse: start edge to valid ≈ (9 + `VERIFY_ON`) × OVERSAMPLE + MID ticks.
- Back-to-back frames are supported. A start edge arriving on the tick right after the return to IDLE is accepted.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each bit decision is a 2-of-3 majority of samples taken at ticks MID−1, MID and MID+1. The decision is committed at MID+1, so all bit events move 1 tick later.
- Not defined: a single sample is taken at MID.
- The state sequence and error semantics are identical either way.

## Structure
- Shared package `uart_pkg` holds:
  - the state localparams (IDLE..BREAK);
  - the default OVERSAMPLE;
  - a `parity_calc(data, even)` function, which `uart_tx_op` shares.
- One sub-module, `uart_rx_sampler`, holds the synchronizer, `tick_cnt` and the optional majority vote. It outputs `bit_strobe` and `bit_val` to the FSM.

## Test plan
- Frame 0xA5, `VERIFY_ON`=0, stop=1 → `dataout_o`=8'hA5, one `data_valid_o` pulse, no error flags, busy drops.
- Frame 0x3C, `VERIFY_ON`=1, `VERIFY_EVEN`=1, parity bit 0 → valid with `parity_err_o`=0. Same frame with parity bit 1 → valid with `parity_err_o`=1.
- Frame 0x55 with stop bit 0 → `frame_err_o` pulse, no valid, `dataout_o` unchanged. Then hold the line low for 20 bit times, release it and send 0x81 → only 0x81 is received.
- Low glitch of 4 ticks on an idle line → no busy after the MID check, no pulses.
- Reset asserted during bit 3 of 0xFF, then frame 0x12 → only 0x12 is reported.
- Back-to-back frames 0x00 then 0xFF with no idle gap → two valid pulses, about 160 ticks apart, with the correct bytes.
